cell4_exerciser: RTL and testbench
==================================

# cell4_exerciser

On-chip built-in self-test sequencer for 4-input / 1-output library cells such as nor4_x1. It walks all 16 input combinations onto a cell under test and samples the cell output after a programmable settle time. It compares each sample against a parameterised truth table and reports a mismatch count, the first failing vector and a pass flag. It sits in the library test-chip harness, one instance per cell under test.

## Interface
- TRUTH, 16'h0001, expected output per vector; bit k = expected rin for input vector k (16'h0001 = NOR4).
- SETTLE, 2, extra cycles each vector is held before sampling; legal range 0..255.
- ck  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- o0, o1, o2, o3  out  1 each  drive cell inputs i0..i3; o0 = v[0] … o3 = v[3] of the current vector index v.
- rin  in  1  cell output (nq) under test; already synchronous to ck.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse after the final sample.
- pass  out  1  high when the last completed sweep had errcnt == 0.
- errcnt  out  5  mismatch count of the current/last sweep (0..16).
- firstfail  out  4  vector index of the first mismatch.
- ffvld  out  1  firstfail is valid.

## Operation
- States: IDLE, APPLY, DONE. Internal: v[3:0], settle counter cnt[7:0].
- Reset (rst=1 at an edge, any state): state=IDLE, v=0, cnt=0, o0..o3=0, busy=0, done=0, pass=0, errcnt=0, firstfail=0, ffvld=0.
- IDLE: o0..o3=0. If start=1, then: state→APPLY, v=0, cnt=SETTLE, errcnt=0, ffvld=0, firstfail=0, pass=0, busy=1.
- APPLY: o = v. If cnt≠0, cnt decrements. If cnt==0, this is the sample cycle: mismatch = rin ^ TRUTH[v].
  - On mismatch: errcnt+1. If ffvld==0, set firstfail=v, ffvld=1.
  - If v==15: state→DONE, busy=0, pass = (final errcnt==0), with the current sample included.
  - Otherwise: v+1, cnt=SETTLE.
- DONE: done=1 for exactly this cycle, o0..o3=0, state→IDLE unconditionally. A start asserted during DONE is ignored.
- start while busy is ignored. No abort input exists; rst is the only abort.
- errcnt never exceeds 16, so no saturation logic is required. Results hold until the next accepted start or rst.
- Reset mid-sweep discards all partial results.

## Timing
- Take T as the cycle in which start=1 is seen in IDLE, and S as SETTLE.
- Vector k is driven during cycles T+1+k(S+1) through T+(k+1)(S+1). It is sampled in the last of those cycles.
- The final sample is in cycle T+16(S+1). done=1, busy=0 and the final errcnt/pass/firstfail are visible in cycle T+16(S+1)+1.
- S=0: one cycle per vector; done at T+17.
- busy is high from T+1 through T+16(S+1) inclusive.
- errcnt/ffvld update on the edge ending each sample cycle. They are visible one cycle later.
- Every output is registered. No combinational path runs from rin or start to any output.

## Test plan
- Ideal NOR4 model (rin = ~(o0|o1|o2|o3) combinational), SETTLE=2, start at T:
  - o sequence 0,1,…,15, each held 3 cycles.
  - done pulse at T+49.
  - errcnt=0, pass=1, ffvld=0.
- rin stuck at 0, SETTLE=2 → errcnt=1, firstfail=0, ffvld=1, pass=0.
- rin stuck at 1, SETTLE=0 → done at T+17; errcnt=15, firstfail=1, ffvld=1, pass=0.
- Ideal model, SETTLE=0; start held high continuously:
  - busy high for 16 cycles.
  - Starts during APPLY/DONE ignored.
  - Next sweep begins the cycle after DONE (IDLE sees start).
  - errcnt reset to 0 at restart.
- rst asserted while v=7 mid-sweep:
  - Next cycle, all outputs are at reset values (o=0, errcnt=0, busy=0).
  - A subsequent start completes a clean sweep with pass=1.
- TRUTH=16'hFFFE with an ideal NOR4 model → errcnt=16, firstfail=0, pass=0.

Source files
------------

// File: rtl/cell4_exerciser.sv
// cell4_exerciser: built-in self-test sequencer for a 4-input / 1-output
// library cell. It walks all 16 input vectors onto the cell under test and
// holds each one for SETTLE+1 cycles. In the last cycle of each vector it
// samples the cell output and compares it against the TRUTH table. At the
// end of the sweep it reports the mismatch count, the first failing vector
// and a pass flag.
//
// Parameters
//   TRUTH     bit k = expected rin for input vector k (16'h0001 = NOR4)
//   SETTLE    extra hold cycles per vector before sampling (0..255)
// Ports
//   ck         clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a sweep (accepted only in IDLE)
//   o0..o3     drive cell inputs i0..i3 with the current vector index
//   rin        cell output under test, synchronous to ck
//   busy       high while sweeping
//   done       one-cycle pulse after the final sample
//   pass       last completed sweep had no mismatches
//   errcnt     mismatch count of the current/last sweep
//   firstfail  vector index of the first mismatch
//   ffvld      firstfail is valid
module cell4_exerciser #(
  parameter logic [15:0] TRUTH  = 16'h0001,
  parameter int unsigned SETTLE = 2
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       start,
  output logic       o0,
  output logic       o1,
  output logic       o2,
  output logic       o3,
  input  logic       rin,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] errcnt,
  output logic [3:0] firstfail,
  output logic       ffvld
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  state_t     state, state_nxt;
  logic [3:0] v, v_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [4:0] errcnt_nxt, err_after;
  logic [3:0] firstfail_nxt;
  logic       ffvld_nxt, pass_nxt;
  logic [3:0] o_q, o_nxt;
  logic       busy_nxt, done_nxt;
  logic       sample, mismatch, last;

  assign sample    = (state == APPLY) && (cnt == '0);
  assign mismatch  = rin ^ TRUTH[v];
  assign last      = (v == 4'hF);
  assign err_after = errcnt + 5'(mismatch);

  // State register
  always_ff @(posedge ck) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = APPLY;
      APPLY:   if (sample && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath next values (vector, settle counter, result accumulation)
  always_comb begin
    v_nxt         = v;
    cnt_nxt       = cnt;
    errcnt_nxt    = errcnt;
    firstfail_nxt = firstfail;
    ffvld_nxt     = ffvld;
    pass_nxt      = pass;
    case (state)
      IDLE: begin
        if (start) begin
          v_nxt         = '0;
          cnt_nxt       = SETTLE_CNT;
          errcnt_nxt    = '0;
          firstfail_nxt = '0;
          ffvld_nxt     = 1'b0;
          pass_nxt      = 1'b0;
        end
      end
      APPLY: begin
        if (!sample) begin
          cnt_nxt = cnt - 8'd1;
        end else begin
          if (mismatch) begin
            errcnt_nxt = err_after;
            if (!ffvld) begin
              firstfail_nxt = v;
              ffvld_nxt     = 1'b1;
            end
          end
          if (last) begin
            // Pass reflects the count including this final sample.
            pass_nxt = (err_after == '0);
          end else begin
            v_nxt   = v + 4'd1;
            cnt_nxt = SETTLE_CNT;
          end
        end
      end
      default: ;
    endcase
  end

  // Output logic: next values of the registered outputs, decoded from the
  // upcoming state so every output is a flop with no path from rin/start.
  always_comb begin
    o_nxt    = (state_nxt == APPLY) ? v_nxt : '0;
    busy_nxt = (state_nxt == APPLY);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      v         <= '0;
      cnt       <= '0;
      errcnt    <= '0;
      firstfail <= '0;
      ffvld     <= 1'b0;
      pass      <= 1'b0;
      o_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      v         <= v_nxt;
      cnt       <= cnt_nxt;
      errcnt    <= errcnt_nxt;
      firstfail <= firstfail_nxt;
      ffvld     <= ffvld_nxt;
      pass      <= pass_nxt;
      o_q       <= o_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  assign o0 = o_q[0];
  assign o1 = o_q[1];
  assign o2 = o_q[2];
  assign o3 = o_q[3];

endmodule

// File: tb/tb_cell4_exerciser.sv
// Testbench for cell4_exerciser. Three instances:
//   dut0: TRUTH=16'h0001, SETTLE=2
//   dut1: TRUTH=16'h0001, SETTLE=0
//   dut2: TRUTH=16'hFFFE, SETTLE=2
// Each instance drives a cell model selected by mode_s[g]:
//   0 = ideal NOR4, 1 = output stuck at 0, 2 = output stuck at 1.
// A timing model derives every output from the start cycle T by arithmetic
// and is compared on every falling edge; directed checks pin key values.
module tb_cell4_exerciser;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic       rst;
  logic       start_s [3];
  int         mode_s  [3];
  logic [3:0] o_s     [3];
  logic       busy_s  [3];
  logic       done_s  [3];
  logic       pass_s  [3];
  logic       ffvld_s [3];
  logic [4:0] err_s   [3];
  logic [3:0] ff_s    [3];

  int     tests = 0;
  int     fails = 0;
  longint cyc   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic d0, d1, d2, d3, rin_l;
    assign rin_l = (mode_s[g] == 0) ? ~(d0 | d1 | d2 | d3) : (mode_s[g] == 2);
    cell4_exerciser #(
      .TRUTH (g == 2 ? 16'hFFFE : 16'h0001),
      .SETTLE(g == 1 ? 0 : 2)
    ) u_dut (
      .ck       (ck),
      .rst      (rst),
      .start    (start_s[g]),
      .o0       (d0),
      .o1       (d1),
      .o2       (d2),
      .o3       (d3),
      .rin      (rin_l),
      .busy     (busy_s[g]),
      .done     (done_s[g]),
      .pass     (pass_s[g]),
      .errcnt   (err_s[g]),
      .firstfail(ff_s[g]),
      .ffvld    (ffvld_s[g])
    );
    assign o_s[g] = {d3, d2, d1, d0};
  end

  function automatic int s_of(input int g);
    return (g == 1) ? 0 : 2;
  endfunction

  function automatic logic [15:0] tr_of(input int g);
    return (g == 2) ? 16'hFFFE : 16'h0001;
  endfunction

  // ---------------- model ----------------
  bit     m_started [3];
  longint m_T       [3];
  int     m_mode    [3];

  function automatic bit model_idle(input int g);
    longint n;
    n = 16 * (s_of(g) + 1);
    return !m_started[g] || ((cyc - m_T[g]) >= n + 2);
  endfunction

  // Cell response for vector j under a given fault mode.
  function automatic bit cell_out(input int mode, input int j);
    if (mode == 0) return (j == 0);
    return (mode == 2);
  endfunction

  always @(posedge ck) begin
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        m_started[g] <= 1'b0;
      end else if (start_s[g] && model_idle(g)) begin
        m_started[g] <= 1'b1;
        m_T[g]       <= cyc;
        m_mode[g]    <= mode_s[g];
      end
    end
    cyc <= cyc + 1;
  end

  function automatic void model_exp(input int g, input longint c,
                                    output logic [3:0] eo, output logic eb,
                                    output logic ed, output logic ep,
                                    output logic ev, output logic [4:0] ee,
                                    output logic [3:0] ef);
    longint d, n, sp1;
    int     nerr, first;
    logic [15:0] tr;
    eo = '0; eb = 1'b0; ed = 1'b0; ep = 1'b0; ev = 1'b0; ee = '0; ef = '0;
    if (!m_started[g]) return;
    sp1 = s_of(g) + 1;
    n   = 16 * sp1;
    d   = c - m_T[g];
    tr  = tr_of(g);
    nerr = 0; first = 0;
    for (int j = 0; j < 16; j++) begin
      // sample of vector j happens at d=(j+1)(S+1), visible one cycle later
      if ((d > n) || ((j + 1) * sp1 <= d - 1)) begin
        if (cell_out(m_mode[g], j) != tr[j]) begin
          if (nerr == 0) first = j;
          nerr++;
        end
      end
    end
    ee = 5'(nerr);
    ev = (nerr != 0);
    ef = 4'(first);
    if (d <= n) begin
      eb = 1'b1;
      eo = 4'((d - 1) / sp1);
    end else begin
      ed = (d == n + 1);
      ep = (nerr == 0);
    end
  endfunction

  task automatic chk(input string name, input int g,
                     input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h",
               name, g, cyc, got, exp);
    end
  endtask

  always @(negedge ck) begin
    logic [3:0] eo, ef;
    logic       eb, ed, ep, ev;
    logic [4:0] ee;
    if (cyc >= 1) begin
      for (int g = 0; g < 3; g++) begin
        model_exp(g, cyc, eo, eb, ed, ep, ev, ee, ef);
        chk("o",         g, 32'(o_s[g]),     32'(eo));
        chk("busy",      g, 32'(busy_s[g]),  32'(eb));
        chk("done",      g, 32'(done_s[g]),  32'(ed));
        chk("pass",      g, 32'(pass_s[g]),  32'(ep));
        chk("ffvld",     g, 32'(ffvld_s[g]), 32'(ev));
        chk("errcnt",    g, 32'(err_s[g]),   32'(ee));
        chk("firstfail", g, 32'(ff_s[g]),    32'(ef));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_to(input longint c);
    while (cyc < c) @(negedge ck);
  endtask

  task automatic pulse_start(input int g, output longint t);
    start_s[g] = 1'b1;
    t = cyc;
    @(negedge ck);
    start_s[g] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t, t2;
    int     nbusy;
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      start_s[g] = 1'b0;
      mode_s[g]  = 0;
    end
    repeat (3) @(negedge ck);
    chk("rst_o",    0, 32'(o_s[0]),    32'd0);
    chk("rst_busy", 0, 32'(busy_s[0]), 32'd0);
    chk("rst_pass", 0, 32'(pass_s[0]), 32'd0);
    chk("rst_err",  0, 32'(err_s[0]),  32'd0);
    rst = 1'b0;
    @(negedge ck);

    // Ideal NOR4, SETTLE=2
    pulse_start(0, t);
    wait_to(t + 3);  chk("s2_o_t3",   0, 32'(o_s[0]), 32'd0);
    wait_to(t + 4);  chk("s2_o_t4",   0, 32'(o_s[0]), 32'd1);
    wait_to(t + 48); chk("s2_busy48", 0, 32'(busy_s[0]), 32'd1);
                     chk("s2_o48",    0, 32'(o_s[0]),    32'd15);
    wait_to(t + 49); chk("s2_done49", 0, 32'(done_s[0]), 32'd1);
                     chk("s2_busy49", 0, 32'(busy_s[0]), 32'd0);
                     chk("s2_err",    0, 32'(err_s[0]),  32'd0);
                     chk("s2_pass",   0, 32'(pass_s[0]), 32'd1);
                     chk("s2_ffvld",  0, 32'(ffvld_s[0]), 32'd0);
    wait_to(t + 50); chk("s2_done50", 0, 32'(done_s[0]), 32'd0);
    repeat (3) @(negedge ck);

    // Stuck at 0, SETTLE=2
    mode_s[0] = 1;
    pulse_start(0, t);
    wait_to(t + 49); chk("sa0_done",  0, 32'(done_s[0]),  32'd1);
                     chk("sa0_err",   0, 32'(err_s[0]),   32'd1);
                     chk("sa0_ff",    0, 32'(ff_s[0]),    32'd0);
                     chk("sa0_ffvld", 0, 32'(ffvld_s[0]), 32'd1);
                     chk("sa0_pass",  0, 32'(pass_s[0]),  32'd0);
    repeat (3) @(negedge ck);

    // Stuck at 1, SETTLE=0
    mode_s[1] = 2;
    pulse_start(1, t);
    wait_to(t + 16); chk("sa1_done16", 1, 32'(done_s[1]), 32'd0);
    wait_to(t + 17); chk("sa1_done",   1, 32'(done_s[1]),  32'd1);
                     chk("sa1_err",    1, 32'(err_s[1]),   32'd15);
                     chk("sa1_ff",     1, 32'(ff_s[1]),    32'd1);
                     chk("sa1_ffvld",  1, 32'(ffvld_s[1]), 32'd1);
                     chk("sa1_pass",   1, 32'(pass_s[1]),  32'd0);
    repeat (3) @(negedge ck);

    // start held high: first sweep stuck-at-1, restart with ideal cell
    start_s[1] = 1'b1;
    t = cyc;
    nbusy = 0;
    for (longint c = t + 1; c <= t + 18; c++) begin
      wait_to(c);
      if (busy_s[1] === 1'b1) nbusy++;
      if (c == t + 17) begin
        chk("hold_err1", 1, 32'(err_s[1]), 32'd15);
        mode_s[1] = 0;
      end
      if (c == t + 18) chk("hold_idle_busy", 1, 32'(busy_s[1]), 32'd0);
    end
    chk("hold_busy_cycles", 1, 32'(nbusy), 32'd16);
    t2 = t + 18;
    wait_to(t2 + 1);  chk("restart_busy", 1, 32'(busy_s[1]), 32'd1);
                      chk("restart_err",  1, 32'(err_s[1]),  32'd0);
    wait_to(t2 + 17); chk("restart_done", 1, 32'(done_s[1]), 32'd1);
                      chk("restart_pass", 1, 32'(pass_s[1]), 32'd1);
    start_s[1] = 1'b0;
    repeat (3) @(negedge ck);

    // Reset mid-sweep at v=7 (stuck-at-0 so partial errcnt is nonzero)
    mode_s[0] = 1;
    pulse_start(0, t);
    wait_to(t + 23); chk("mid_o7",   0, 32'(o_s[0]),   32'd7);
                     chk("mid_err1", 0, 32'(err_s[0]), 32'd1);
    rst = 1'b1;
    @(negedge ck);
    chk("rst_mid_o",     0, 32'(o_s[0]),     32'd0);
    chk("rst_mid_err",   0, 32'(err_s[0]),   32'd0);
    chk("rst_mid_busy",  0, 32'(busy_s[0]),  32'd0);
    chk("rst_mid_ffvld", 0, 32'(ffvld_s[0]), 32'd0);
    rst = 1'b0;
    mode_s[0] = 0;
    repeat (2) @(negedge ck);
    pulse_start(0, t);
    wait_to(t + 49); chk("post_rst_done", 0, 32'(done_s[0]), 32'd1);
                     chk("post_rst_pass", 0, 32'(pass_s[0]), 32'd1);
    repeat (3) @(negedge ck);

    // Inverted truth table with ideal NOR4
    mode_s[2] = 0;
    pulse_start(2, t);
    wait_to(t + 49); chk("inv_done",  2, 32'(done_s[2]),  32'd1);
                     chk("inv_err",   2, 32'(err_s[2]),   32'd16);
                     chk("inv_ff",    2, 32'(ff_s[2]),    32'd0);
                     chk("inv_ffvld", 2, 32'(ffvld_s[2]), 32'd1);
                     chk("inv_pass",  2, 32'(pass_s[2]),  32'd0);
    repeat (3) @(negedge ck);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
